// File: rtl/move_sequencer.sv
// move_sequencer: number register file for the 24 game. Every player move is
// checked for legality and run through a shared arithmetic unit. Add, sub and
// mul complete in one cycle; divide uses an iterative restoring divider. The
// block also keeps a 3-deep undo history and the dealt set for restart.
//
// state | meaning
// IDLE  | waiting for a move or a control event
// CHECK | legality check of the latched move
// EXEC  | single-cycle add/sub/mul write-back
// DIV   | W restoring-divide iterations, then remainder check and write-back
module move_sequencer #(
  parameter int W      = 10,
  parameter int TARGET = 24
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic [4*W-1:0] load_nums,
  input  logic           restart,
  input  logic           undo,
  input  logic           mv_valid,
  output logic           mv_ready,
  input  logic [1:0]     mv_sel_a,
  input  logic [1:0]     mv_sel_b,
  input  logic [1:0]     mv_op,
  output logic [W-1:0]   num1,
  output logic [W-1:0]   num2,
  output logic [W-1:0]   num3,
  output logic [W-1:0]   num4,
  output logic [3:0]     valid_mask,
  output logic           busy,
  output logic           err,
  output logic [1:0]     err_code,
  output logic           win,
  output logic           lose
);

  localparam int SW = 4 * W;
  localparam int HW = SW + 4;
  localparam int CW = $clog2(W + 1);
  localparam logic [W-1:0] TGT = W'(TARGET);

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_EXEC, S_DIV} state_e;

  state_e            state_q, state_d;
  logic [SW-1:0]     slots_q, slots_d;
  logic [SW-1:0]     saved_q, saved_d;
  logic [3:0]        mask_q, mask_d;
  logic [2:0][HW-1:0] hist_q, hist_d;
  logic [1:0]        hcnt_q, hcnt_d;
  logic [1:0]        sel_a_q, sel_a_d, sel_b_q, sel_b_d, op_q, op_d;
  logic              err_q, err_d;
  logic [1:0]        code_q, code_d;
  logic              win_q, win_d, lose_q, lose_d;
  logic [W-1:0]      rem_q, rem_d, quo_q, quo_d;
  logic [CW-1:0]     dcnt_q, dcnt_d;

  logic [W-1:0]      opa, opb, alu_res, wb_val;
  logic [W:0]        sum;
  logic [2*W-1:0]    prod;
  logic [W:0]        shifted;
  logic [W+1:0]      trial;
  logic [1:0]        lo_sel, hi_sel;
  logic [SW-1:0]     wb_slots;
  logic [3:0]        wb_mask;
  logic              wr_en;

  function automatic logic [W-1:0] slot_get(input logic [SW-1:0] v, input logic [1:0] i);
    logic [W-1:0] r;
    r = v[0 +: W];
    case (i)
      2'd1:    r = v[W +: W];
      2'd2:    r = v[2*W +: W];
      2'd3:    r = v[3*W +: W];
      default: r = v[0 +: W];
    endcase
    return r;
  endfunction

  // Operand fetch, arithmetic unit and one restoring-divide step.
  always_comb begin
    opa     = slot_get(slots_q, sel_a_q);
    opb     = slot_get(slots_q, sel_b_q);
    sum     = {1'b0, opa} + {1'b0, opb};
    prod    = {{W{1'b0}}, opa} * {{W{1'b0}}, opb};
    shifted = {rem_q, quo_q[W-1]};
    trial   = {1'b0, shifted} - {2'b00, opb};
    case (op_q)
      OP_ADD:  alu_res = sum[W-1:0];
      OP_SUB:  alu_res = opa - opb;
      OP_MUL:  alu_res = prod[W-1:0];
      default: alu_res = quo_q;
    endcase
  end

  // Write-back image: result lands in the lower slot, the higher slot retires.
  always_comb begin
    lo_sel   = (sel_a_q < sel_b_q) ? sel_a_q : sel_b_q;
    hi_sel   = (sel_a_q < sel_b_q) ? sel_b_q : sel_a_q;
    wb_val   = (state_q == S_DIV) ? quo_q : alu_res;
    wb_slots = slots_q;
    for (int i = 0; i < 4; i++) begin
      if (i == int'(lo_sel)) wb_slots[i*W +: W] = wb_val;
    end
    wb_mask = mask_q & ~(4'b0001 << hi_sel);
  end

  // Moves are only taken from IDLE with at least two numbers left and no control pulse.
  always_comb begin
    mv_ready = (state_q == S_IDLE) && ($countones(mask_q) >= 2) && !load && !restart && !undo;
  end

  // Next-state logic: control events, move sequencing, history and game result.
  always_comb begin
    state_d = state_q;
    slots_d = slots_q;
    saved_d = saved_q;
    mask_d  = mask_q;
    hist_d  = hist_q;
    hcnt_d  = hcnt_q;
    sel_a_d = sel_a_q;
    sel_b_d = sel_b_q;
    op_d    = op_q;
    err_d   = 1'b0;
    code_d  = code_q;
    win_d   = win_q;
    lose_d  = lose_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dcnt_d  = dcnt_q;
    wr_en   = 1'b0;

    if (load) begin
      slots_d = load_nums;
      saved_d = load_nums;
      mask_d  = 4'hF;
      hist_d  = '0;
      hcnt_d  = '0;
      win_d   = 1'b0;
      lose_d  = 1'b0;
      code_d  = 2'd0;
      state_d = S_IDLE;
    end else if (restart) begin
      slots_d = saved_q;
      mask_d  = 4'hF;
      hist_d  = '0;
      hcnt_d  = '0;
      win_d   = 1'b0;
      lose_d  = 1'b0;
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (undo) begin
            if (hcnt_q != 2'd0) begin
              {slots_d, mask_d} = hist_q[hcnt_q - 2'd1];
              hcnt_d = hcnt_q - 2'd1;
              win_d  = 1'b0;
              lose_d = 1'b0;
            end
          end else if (mv_valid && mv_ready) begin
            sel_a_d = mv_sel_a;
            sel_b_d = mv_sel_b;
            op_d    = mv_op;
            state_d = S_CHECK;
          end
        end
        S_CHECK: begin
          state_d = S_IDLE;
          if ((sel_a_q == sel_b_q) || !mask_q[sel_a_q] || !mask_q[sel_b_q]) begin
            err_d  = 1'b1;
            code_d = 2'd0;
          end else if (op_q == OP_DIV && opb == '0) begin
            err_d  = 1'b1;
            code_d = 2'd1;
          end else if (op_q == OP_SUB && opa < opb) begin
            err_d  = 1'b1;
            code_d = 2'd2;
          end else if ((op_q == OP_MUL && prod[2*W-1:W] != '0) || (op_q == OP_ADD && sum[W])) begin
            err_d  = 1'b1;
            code_d = 2'd3;
          end else if (op_q == OP_DIV) begin
            rem_d   = '0;
            quo_d   = opa;
            dcnt_d  = CW'(W);
            state_d = S_DIV;
          end else begin
            state_d = S_EXEC;
          end
        end
        S_EXEC: begin
          wr_en   = 1'b1;
          state_d = S_IDLE;
        end
        S_DIV: begin
          if (dcnt_q != '0) begin
            if (!trial[W+1]) begin
              rem_d = trial[W-1:0];
              quo_d = {quo_q[W-2:0], 1'b1};
            end else begin
              rem_d = shifted[W-1:0];
              quo_d = {quo_q[W-2:0], 1'b0};
            end
            dcnt_d = dcnt_q - CW'(1);
          end else begin
            state_d = S_IDLE;
            if (rem_q != '0) begin
              err_d  = 1'b1;
              code_d = 2'd1;
            end else begin
              wr_en = 1'b1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase

      if (wr_en) begin
        slots_d = wb_slots;
        mask_d  = wb_mask;
        if (hcnt_q == 2'd3) begin
          hist_d[0] = hist_q[1];
          hist_d[1] = hist_q[2];
          hist_d[2] = {slots_q, mask_q};
        end else begin
          hist_d[hcnt_q] = {slots_q, mask_q};
          hcnt_d = hcnt_q + 2'd1;
        end
        if ($countones(wb_mask) == 1) begin
          win_d  = (wb_slots[W-1:0] == TGT);
          lose_d = (wb_slots[W-1:0] != TGT);
        end
      end
    end
  end

  // State register and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      slots_q <= '0;
      saved_q <= '0;
      mask_q  <= '0;
      hist_q  <= '0;
      hcnt_q  <= '0;
      sel_a_q <= '0;
      sel_b_q <= '0;
      op_q    <= '0;
      err_q   <= 1'b0;
      code_q  <= '0;
      win_q   <= 1'b0;
      lose_q  <= 1'b0;
      rem_q   <= '0;
      quo_q   <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      slots_q <= slots_d;
      saved_q <= saved_d;
      mask_q  <= mask_d;
      hist_q  <= hist_d;
      hcnt_q  <= hcnt_d;
      sel_a_q <= sel_a_d;
      sel_b_q <= sel_b_d;
      op_q    <= op_d;
      err_q   <= err_d;
      code_q  <= code_d;
      win_q   <= win_d;
      lose_q  <= lose_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dcnt_q  <= dcnt_d;
    end
  end

  assign num1       = slots_q[0 +: W];
  assign num2       = slots_q[W +: W];
  assign num3       = slots_q[2*W +: W];
  assign num4       = slots_q[3*W +: W];
  assign valid_mask = mask_q;
  assign busy       = (state_q != S_IDLE);
  assign err        = err_q;
  assign err_code   = code_q;
  assign win        = win_q;
  assign lose       = lose_q;

endmodule

// File: tb/tb_move_sequencer.sv
// Bench for move_sequencer: an event-level game model predicts every output
// each cycle; directed literal checks pin the model at key points.
module tb_move_sequencer;
  localparam int W = 10;

  logic           clk, rst_n, load, restart, undo, mv_valid;
  logic [4*W-1:0] load_nums;
  logic [1:0]     mv_sel_a, mv_sel_b, mv_op;
  logic           mv_ready, busy, err, win, lose;
  logic [W-1:0]   num1, num2, num3, num4;
  logic [3:0]     valid_mask;
  logic [1:0]     err_code;

  int n_cmp = 0;
  int n_bad = 0;

  move_sequencer #(.W(W), .TARGET(24)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .load_nums(load_nums),
    .restart(restart), .undo(undo), .mv_valid(mv_valid), .mv_ready(mv_ready),
    .mv_sel_a(mv_sel_a), .mv_sel_b(mv_sel_b), .mv_op(mv_op),
    .num1(num1), .num2(num2), .num3(num3), .num4(num4),
    .valid_mask(valid_mask), .busy(busy), .err(err), .err_code(err_code),
    .win(win), .lose(lose)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- game model ----------------
  typedef struct packed {
    logic [W-1:0] s0, s1, s2, s3;
    logic [3:0]   m;
  } snap_t;

  int    ms[4];
  int    sv[4];
  bit [3:0] mm;
  snap_t hq[$];
  int    pend;
  bit    p_rej;
  int    p_code, p_val, p_lo, p_hi;
  bit    m_err, m_win, m_lose;
  int    m_code;

  function automatic bit m_ready();
    return (pend == 0) && ($countones(mm) >= 2) && !load && !restart && !undo;
  endfunction

  task automatic m_schedule(input int a, input int b, input int op);
    int x, y;
    x = ms[a];
    y = ms[b];
    p_lo = (a < b) ? a : b;
    p_hi = (a < b) ? b : a;
    p_rej = 1'b1;
    pend = 1;
    if (a == b || !mm[a] || !mm[b]) p_code = 0;
    else begin
      case (op)
        0: if (x + y >= (1 << W)) p_code = 3; else begin p_rej = 1'b0; p_val = x + y; pend = 2; end
        1: if (x < y) p_code = 2; else begin p_rej = 1'b0; p_val = x - y; pend = 2; end
        2: if (x * y >= (1 << W)) p_code = 3; else begin p_rej = 1'b0; p_val = x * y; pend = 2; end
        default: begin
          if (y == 0) p_code = 1;
          else begin
            pend = W + 2;
            if (x % y != 0) p_code = 1;
            else begin p_rej = 1'b0; p_val = x / y; end
          end
        end
      endcase
    end
  endtask

  task automatic m_resolve();
    snap_t s;
    if (p_rej) begin
      m_err = 1'b1;
      m_code = p_code;
    end else begin
      s.s0 = W'(ms[0]); s.s1 = W'(ms[1]); s.s2 = W'(ms[2]); s.s3 = W'(ms[3]); s.m = mm;
      hq.push_back(s);
      if (hq.size() > 3) void'(hq.pop_front());
      ms[p_lo] = p_val;
      mm[p_hi] = 1'b0;
      if ($countones(mm) == 1) begin
        m_win = (ms[0] == 24);
        m_lose = !m_win;
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin ms[i] = 0; sv[i] = 0; end
      mm = 4'h0; hq.delete(); pend = 0;
      m_err = 1'b0; m_code = 0; m_win = 1'b0; m_lose = 1'b0;
    end else begin
      bit rdy;
      snap_t s;
      rdy = m_ready();
      m_err = 1'b0;
      if (load) begin
        for (int i = 0; i < 4; i++) begin ms[i] = int'(load_nums[i*W +: W]); sv[i] = ms[i]; end
        mm = 4'hF; hq.delete(); pend = 0;
        m_win = 1'b0; m_lose = 1'b0; m_code = 0;
      end else if (restart) begin
        for (int i = 0; i < 4; i++) ms[i] = sv[i];
        mm = 4'hF; hq.delete(); pend = 0;
        m_win = 1'b0; m_lose = 1'b0;
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) m_resolve();
      end else if (undo) begin
        if (hq.size() > 0) begin
          s = hq.pop_back();
          ms[0] = int'(s.s0); ms[1] = int'(s.s1); ms[2] = int'(s.s2); ms[3] = int'(s.s3);
          mm = s.m;
          m_win = 1'b0; m_lose = 1'b0;
        end
      end else if (mv_valid && rdy) begin
        m_schedule(int'(mv_sel_a), int'(mv_sel_b), int'(mv_op));
      end
    end
  end

  // Per-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    chk("num1", int'(num1), ms[0]);
    chk("num2", int'(num2), ms[1]);
    chk("num3", int'(num3), ms[2]);
    chk("num4", int'(num4), ms[3]);
    chk("valid_mask", int'(valid_mask), int'(mm));
    chk("busy", int'(busy), int'(pend > 0));
    chk("err", int'(err), int'(m_err));
    chk("err_code", int'(err_code), m_code);
    chk("win", int'(win), int'(m_win));
    chk("lose", int'(lose), int'(m_lose));
    chk("mv_ready", int'(mv_ready), int'(m_ready()));
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int a, input int b, input int c, input int d);
    load_nums = {W'(d), W'(c), W'(b), W'(a)};
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic pulse_undo();
    undo = 1'b1;
    tick();
    undo = 1'b0;
  endtask

  task automatic start_move(input int a, input int b, input int op);
    int k;
    k = 0;
    mv_sel_a = 2'(a); mv_sel_b = 2'(b); mv_op = 2'(op);
    mv_valid = 1'b1;
    #1;
    while (!mv_ready && k < 20) begin @(posedge clk); #2; k++; end
    if (k >= 20) chk("handshake_timeout", 0, 1);
    @(posedge clk);
    #1;
    mv_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (busy && lat < 40) begin @(posedge clk); #1; lat++; end
    if (busy) chk("done_timeout", 0, 1);
  endtask

  task automatic do_move(input int a, input int b, input int op, output int lat);
    start_move(a, b, op);
    wait_done(lat);
  endtask

  initial begin
    int lat;
    rst_n = 1'b0; load = 1'b0; restart = 1'b0; undo = 1'b0; mv_valid = 1'b1;
    load_nums = '0; mv_sel_a = 2'd0; mv_sel_b = 2'd1; mv_op = 2'd0;

    // 1: reset with mv_valid asserted, then no load
    tick(3);
    chk("t1_rst_num1", int'(num1), 0);
    chk("t1_rst_mask", int'(valid_mask), 0);
    chk("t1_rst_ready", int'(mv_ready), 0);
    rst_n = 1'b1;
    tick(3);
    chk("t1_noload_ready", int'(mv_ready), 0);
    mv_valid = 1'b0;

    // 2: winning line
    do_load(6, 4, 1, 1);
    do_move(0, 1, 2, lat);
    chk("t2_mul_lat", lat, 2);
    chk("t2_num1", int'(num1), 24);
    chk("t2_mask", int'(valid_mask), 4'b1101);
    do_move(2, 3, 2, lat);
    chk("t2_num3", int'(num3), 1);
    chk("t2_mask2", int'(valid_mask), 4'b0101);
    do_move(0, 2, 2, lat);
    chk("t2_win_num1", int'(num1), 24);
    chk("t2_win_mask", int'(valid_mask), 4'b0001);
    chk("t2_win", int'(win), 1);
    chk("t2_ready_end", int'(mv_ready), 0);

    // 3: divides, undo while busy ignored
    do_load(9, 3, 8, 0);
    do_move(0, 1, 3, lat);
    chk("t3_div_lat", lat, W + 2);
    chk("t3_div_num1", int'(num1), 3);
    do_move(2, 3, 3, lat);
    chk("t3_div0_lat", lat, 1);
    chk("t3_div0_code", int'(err_code), 1);
    chk("t3_div0_num3", int'(num3), 8);
    start_move(0, 2, 0);
    undo = 1'b1;
    tick();
    undo = 1'b0;
    wait_done(lat);
    chk("t3_add_num1", int'(num1), 11);
    chk("t3_add_mask", int'(valid_mask), 4'b1001);
    pulse_undo();
    chk("t3_undo_num1", int'(num1), 3);
    do_load(7, 2, 5, 5);
    do_move(0, 1, 3, lat);
    chk("t3_inexact_lat", lat, W + 2);
    chk("t3_inexact_code", int'(err_code), 1);
    chk("t3_inexact_num1", int'(num1), 7);

    // 4: rejections
    do_load(3, 5, 40, 30);
    do_move(0, 1, 1, lat);
    chk("t4_neg_code", int'(err_code), 2);
    do_move(1, 1, 0, lat);
    chk("t4_same_code", int'(err_code), 0);
    do_move(2, 3, 2, lat);
    chk("t4_ovf_code", int'(err_code), 3);
    chk("t4_ovf_mask", int'(valid_mask), 4'b1111);

    // 5: undo history
    do_load(6, 4, 1, 1);
    do_move(0, 1, 2, lat);
    do_move(2, 3, 2, lat);
    pulse_undo();
    chk("t5_u1_num1", int'(num1), 24);
    chk("t5_u1_mask", int'(valid_mask), 4'b1101);
    pulse_undo();
    chk("t5_u2_num1", int'(num1), 6);
    chk("t5_u2_mask", int'(valid_mask), 4'b1111);
    pulse_undo();
    chk("t5_u3_num1", int'(num1), 6);
    do_move(0, 1, 0, lat);
    do_move(2, 3, 0, lat);
    do_move(0, 2, 2, lat);
    chk("t5_lose", int'(lose), 1);
    pulse_undo();
    do_move(0, 2, 1, lat);
    chk("t5_sub_num1", int'(num1), 8);
    repeat (4) pulse_undo();
    chk("t5_back_num1", int'(num1), 6);
    chk("t5_back_mask", int'(valid_mask), 4'b1111);
    chk("t5_back_lose", int'(lose), 0);

    // 6: restart aborts a divide; load beats restart and move
    do_load(9, 3, 8, 2);
    start_move(0, 1, 3);
    tick(4);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("t6_busy", int'(busy), 0);
    chk("t6_num1", int'(num1), 9);
    tick(15);
    chk("t6_late_num1", int'(num1), 9);
    chk("t6_late_mask", int'(valid_mask), 4'b1111);
    load_nums = {W'(4), W'(3), W'(2), W'(1)};
    mv_sel_a = 2'd0; mv_sel_b = 2'd1; mv_op = 2'd0;
    load = 1'b1; restart = 1'b1; mv_valid = 1'b1;
    tick();
    load = 1'b0; restart = 1'b0; mv_valid = 1'b0;
    tick();
    chk("t6_load_num1", int'(num1), 1);
    chk("t6_load_num4", int'(num4), 4);
    chk("t6_load_busy", int'(busy), 0);

    tick(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
